// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: consumer end of the stall interface in the 5-stage pipeline.
// Turns load-use hold, branch redirect and mult/div start into the PC / IF/ID
// enables, the IF/ID flush and the ID/EX bubble select. It also sequences the
// mult/div busy period and runs a load-use stall watchdog.
// Optional feature: define PIPE_STATS_EN to build the stall/flush statistics
// counters. When it is not defined, both stats outputs are tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | normal issue; branch > md_start > hold_sig resolved here
// ST_BUSY | mult/div occupies EX; frontend frozen, md_cnt counts down
module pipeline_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned MAX_STALL  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_sig,
  input  logic        branch_taken,
  input  logic        md_start,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic        stall_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_BUSY = 1'b1} state_t;

  // The RUN start cycle is one frozen cycle, so BUSY only needs MD_LATENCY-1
  // cycles. Those cycles are counted down from MD_LATENCY-2 to 0.
  localparam logic [4:0] MD_LOAD = 5'(MD_LATENCY - 2);
  localparam logic [8:0] ERR_LEN = 9'(MAX_STALL + 1);

  state_t     state_q, state_d;
  logic [4:0] md_cnt_q, md_cnt_d;
  logic [7:0] run_len_q, run_len_d;
  logic [8:0] run_len_inc;
  logic       stall_err_q, stall_err_d;

  // State, mult/div countdown, stall run length and sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= 5'd0;
      run_len_q   <= 8'd0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      run_len_q   <= run_len_d;
      stall_err_q <= stall_err_d;
    end
  end

  // Next state, counter updates and combinational enable/flush decode
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    run_len_d   = run_len_q;
    stall_err_d = stall_err_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_done     = 1'b0;
    // The increment is 9 bits wide so that MAX_STALL=255 can still trip the
    // watchdog after run_len has saturated at 255.
    run_len_inc = {1'b0, run_len_q} + 9'd1;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          // The load-use dependent instruction is squashed, so hold_sig does not matter.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          run_len_d   = 8'd0;
        end else if (md_start) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          md_cnt_d    = MD_LOAD;
          run_len_d   = 8'd0;
          state_d     = ST_BUSY;
        end else if (!hold_sig) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          run_len_d   = (run_len_q == 8'hFF) ? 8'hFF : run_len_inc[7:0];
          if (run_len_inc == ERR_LEN) begin
            stall_err_d = 1'b1;
          end
        end else begin
          run_len_d = 8'd0;
        end
      end

      ST_BUSY: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        run_len_d   = 8'd0;
        if (md_cnt_q == 5'd0) begin
          md_done = 1'b1;
          state_d = ST_RUN;
        end else begin
          md_cnt_d = md_cnt_q - 5'd1;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  assign md_busy   = (state_q == ST_BUSY);
  assign stall_err = stall_err_q;

`ifdef PIPE_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Free-running statistics; the counters wrap naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (!pc_write) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (ifid_flush) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer end of the stall interface. Receives the registered load-use hold request (`hold_sig`, active-low) from the hazard detection unit, the EX-stage branch redirect, and the multi-cycle mult/div start.
- Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX control-bubble mux select.
- Owns the mult/div busy sequencing and a stall watchdog. Sits between the hazard detection unit and the PC, IF/ID and control-zeroing mux in the 5-stage MIPS pipeline.

Parameters:
- MD_LATENCY, 4: total EX-stage cycles of a mult/div operation; legal range 2..32.
- MAX_STALL, 8: consecutive load-use stall cycles tolerated before `stall_err` is raised; legal range 1..255.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hold_sig  input  1  load-use request from the hazard detector; 0 = stall, 1 = run.
- branch_taken  input  1  EX-stage redirect; 1 = flush younger instructions.
- md_start  input  1  one-cycle pulse; mult/div instruction has entered EX.
- pc_write  output  1  1 = PC loads its next value.
- ifid_write  output  1  1 = IF/ID register loads.
- ifid_flush  output  1  1 = IF/ID loads a NOP.
- idex_bubble  output  1  1 = control mux selects all-zero control into ID/EX.
- md_busy  output  1  1 while a mult/div is in progress.
- md_done  output  1  one-cycle pulse on the last mult/div cycle.
- stall_err  output  1  sticky watchdog flag.
- stall_cycles  output  32  stats counter (see Optional Feature).
- flush_count  output  32  stats counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - State=RUN; counters cleared.
  - pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, md_busy=0, md_done=0, stall_err=0, stall counters=0.
  - Outputs take these values immediately, without waiting for a clock edge.
- State register: RUN, BUSY. Enable/flush outputs are combinational from state and inputs. md_busy is decoded from state. All counters are registered.
- RUN, priority branch_taken > md_start > hold_sig:
  - branch_taken=1:
    - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
    - hold_sig is ignored, because the dependent instruction is squashed.
    - md_start in the same cycle is ignored.
  - md_start=1 (no branch):
    - pc_write=0, ifid_write=0, idex_bubble=1.
    - md_cnt <= MD_LATENCY-2; next state BUSY.
  - hold_sig=0 (no branch, no md_start):
    - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
    - run_len increments, saturating at 255.
  - Otherwise: normal flow (reset values); run_len <= 0.
- BUSY:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, md_busy=1.
  - branch_taken, hold_sig and md_start are ignored; EX holds the mult/div.
  - md_cnt decrements each cycle.
  - When md_cnt==0: md_done=1 for that cycle and next state is RUN.
  - Total BUSY cycles = MD_LATENCY-1; with the RUN start cycle, the frontend is frozen for exactly MD_LATENCY cycles.
- Watchdog:
  - run_len counts consecutive RUN cycles with hold_sig=0 and no branch.
  - When the increment makes run_len equal MAX_STALL+1, stall_err <= 1.
  - stall_err stays set until reset. Asserting it does not change the enables.
  - run_len clears on any non-stall cycle and on entry to BUSY.
- Enable invariants:
  - ifid_flush=1 implies ifid_write=1.
  - pc_write==ifid_write in every cycle.
- Reset mid-BUSY aborts the operation: md_done is not pulsed and the block returns to RUN.
- Back-to-back: md_start on the cycle after md_done is accepted, giving a new BUSY period with no RUN gap beyond that cycle.

Optional Feature:
- Macro PIPE_STATS_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every cycle with ifid_flush=1.
  - Both counters are 32 bits, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: both outputs are constant 0 and no counter flops are synthesized.

Test Plan:
- Release reset, hold_sig=1, no requests for 5 cycles -> pc_write=ifid_write=1, idex_bubble=0 every cycle; stall_err=0.
- hold_sig=0 for 1 cycle -> that cycle has pc_write=0, ifid_write=0, idex_bubble=1; the next cycle is back to normal; with PIPE_STATS_EN, stall_cycles=1.
- hold_sig=0 and branch_taken=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_cycles unchanged; flush_count=1.
- MD_LATENCY=4, md_start pulse -> pc_write=0 for exactly 4 cycles; md_busy=1 for 3 cycles; md_done on the 4th cycle; branch_taken=1 injected in BUSY has no effect.
- MAX_STALL=8, hold_sig=0 for 9 cycles -> stall_err rises on the edge ending the 9th stall cycle; it stays 1 after hold_sig=1 until rst_n=0.
- Assert rst_n=0 during cycle 2 of BUSY -> outputs immediately return to reset values; no md_done pulse; the next md_start takes the full MD_LATENCY cycles.
